// File: rtl/integer_exec_unit_if.sv
// Issue-queue and CDB signal bundle for the integer execution unit.
// master: issue queue / CDB arbiter side; slave: the execution unit.
// Flow control is a ready/done issue handshake plus a valid/grant CDB handshake.
interface integer_exec_unit_if;
    logic        issueque_ready;
    logic [31:0] issueque_rs_data;
    logic [31:0] issueque_rt_data;
    logic [5:0]  issueque_rd_tag;
    logic [6:0]  issueque_opcode;
    logic [2:0]  issueque_funct3;
    logic [6:0]  issueque_funct7;
    logic        issueblk_done;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant;

    modport master (
        output issueque_ready, issueque_rs_data, issueque_rt_data, issueque_rd_tag,
               issueque_opcode, issueque_funct3, issueque_funct7, cdb_grant,
        input  issueblk_done, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  issueque_ready, issueque_rs_data, issueque_rt_data, issueque_rd_tag,
               issueque_opcode, issueque_funct3, issueque_funct7, cdb_grant,
        output issueblk_done, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/integer_exec_unit.sv
// Two-stage integer ALU (EX register -> result register) feeding the CDB.
// Latency: accepted at cycle N, result on CDB at N+2; one instruction per cycle under continuous grant.
// Backpressure: without cdb_grant the result is held and EX stalls once both stages are full.
module integer_exec_unit (
    input  logic              clk,
    input  logic              reset,
    integer_exec_unit_if.slave eu
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [5:0]  tag;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } ex_t;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } res_t;

    logic        ex_valid;
    ex_t         ex_q;
    logic        res_valid;
    res_t        res_q;
    logic        res_advance;
    logic        ex_free;
    logic        issue_done;
    logic [31:0] alu_out;
    logic [4:0]  shamt;
    logic        alt;
    logic        unused_funct7;

    assign res_advance = ex_valid && (!res_valid || eu.cdb_grant);
    assign ex_free     = !ex_valid || res_advance;
    assign issue_done  = eu.issueque_ready && ex_free && !reset;

    assign eu.issueblk_done = issue_done;
    assign eu.cdb_valid     = res_valid;
    assign eu.cdb_tag       = res_q.tag;
    assign eu.cdb_data      = res_q.data;

    assign shamt         = ex_q.rt_data[4:0];
    assign alt           = ex_q.funct7[5];
    assign unused_funct7 = ^{ex_q.funct7[6], ex_q.funct7[4:0]};

    always_comb begin
        alu_out = '0;
        case (ex_q.opcode)
            OP_R, OP_I: begin
                case (ex_q.funct3)
                    3'b000: begin
                        // Immediate forms carry arbitrary upper bits, so SUB exists only for R-type.
                        if (ex_q.opcode == OP_R && alt)
                            alu_out = ex_q.rs_data - ex_q.rt_data;
                        else
                            alu_out = ex_q.rs_data + ex_q.rt_data;
                    end
                    3'b001: alu_out = ex_q.rs_data << shamt;
                    3'b010: alu_out = {31'd0, $signed(ex_q.rs_data) < $signed(ex_q.rt_data)};
                    3'b011: alu_out = {31'd0, ex_q.rs_data < ex_q.rt_data};
                    3'b100: alu_out = ex_q.rs_data ^ ex_q.rt_data;
                    3'b101: begin
                        if (alt)
                            alu_out = $unsigned($signed(ex_q.rs_data) >>> shamt);
                        else
                            alu_out = ex_q.rs_data >> shamt;
                    end
                    3'b110: alu_out = ex_q.rs_data | ex_q.rt_data;
                    default: alu_out = ex_q.rs_data & ex_q.rt_data;
                endcase
            end
            OP_LUI:  alu_out = ex_q.rt_data;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_q      <= '0;
            res_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            if (issue_done) begin
                ex_valid     <= 1'b1;
                ex_q.rs_data <= eu.issueque_rs_data;
                ex_q.rt_data <= eu.issueque_rt_data;
                ex_q.tag     <= eu.issueque_rd_tag;
                ex_q.opcode  <= eu.issueque_opcode;
                ex_q.funct3  <= eu.issueque_funct3;
                ex_q.funct7  <= eu.issueque_funct7;
            end else if (res_advance) begin
                ex_valid <= 1'b0;
            end

            if (res_advance) begin
                res_valid  <= 1'b1;
                res_q.tag  <= ex_q.tag;
                res_q.data <= alu_out;
            end else if (res_valid && eu.cdb_grant) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_integer_exec_unit.sv
// Directed-vector bench for integer_exec_unit: streamed ALU table plus stall, reset and grant sequences.
module tb_integer_exec_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    integer_exec_unit_if bus ();

    integer_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .eu    (bus)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  tag;
        logic [31:0] exp;
    } vec_t;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] F7A = 7'b0100000;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.issueque_ready    = 1'b1;
        bus.issueque_rs_data  = v.rs;
        bus.issueque_rt_data  = v.rt;
        bus.issueque_rd_tag   = v.tag;
        bus.issueque_opcode   = v.op;
        bus.issueque_funct3   = v.f3;
        bus.issueque_funct7   = v.f7;
    endtask

    task automatic chk_cdb(input string name, input logic v, input logic [5:0] t, input logic [31:0] d);
        chk({name, ".valid"}, {31'd0, bus.cdb_valid}, {31'd0, v});
        chk({name, ".tag"},   {26'd0, bus.cdb_tag},   {26'd0, t});
        chk({name, ".data"},  bus.cdb_data, d);
    endtask

    function automatic vec_t mk(input logic [31:0] rs, input logic [31:0] rt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [5:0] tag,
                                input logic [31:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.op = op; v.f3 = f3; v.f7 = f7; v.tag = tag; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t a, b, c;
        int n;

        vecs.push_back(mk(32'd5,          32'd7,          R,     3'b000, 7'd0, 6'd12, 32'd12));
        vecs.push_back(mk(32'd3,          32'd5,          R,     3'b000, F7A,  6'd1,  32'hFFFFFFFE));
        vecs.push_back(mk(32'h80000000,   32'd4,          R,     3'b101, F7A,  6'd2,  32'hF8000000));
        vecs.push_back(mk(32'h80000000,   32'd4,          R,     3'b101, 7'd0, 6'd3,  32'h08000000));
        vecs.push_back(mk(32'd1,          32'hFFFFFFFF,   R,     3'b011, 7'd0, 6'd4,  32'd1));
        vecs.push_back(mk(32'd1,          32'hFFFFFFFF,   R,     3'b010, 7'd0, 6'd5,  32'd0));
        vecs.push_back(mk(32'd1,          32'h00000025,   R,     3'b001, 7'd0, 6'd6,  32'h00000020));
        vecs.push_back(mk(32'hF0F0F0F0,   32'hFF00FF00,   R,     3'b100, 7'd0, 6'd7,  32'h0FF00FF0));
        vecs.push_back(mk(32'hF0F0F0F0,   32'h0F0F0000,   R,     3'b110, 7'd0, 6'd8,  32'hFFFFF0F0));
        vecs.push_back(mk(32'hF0F0F0F0,   32'hFF00FF00,   R,     3'b111, 7'd0, 6'd10, 32'hF000F000));
        vecs.push_back(mk(32'd3,          32'd5,          I,     3'b000, F7A,  6'd11, 32'd8));
        vecs.push_back(mk(32'h80000000,   32'd4,          I,     3'b101, F7A,  6'd13, 32'hF8000000));
        vecs.push_back(mk(32'h0,          32'h12345000,   LUI,   3'b000, 7'd0, 6'd14, 32'h12345000));
        vecs.push_back(mk(32'd5,          32'd7,          7'b1100011, 3'b000, 7'd0, 6'd9, 32'd0));
        vecs.push_back(mk(32'hFFFFFFFF,   32'd2,          R,     3'b000, 7'd0, 6'd15, 32'd1));
        vecs.push_back(mk(32'hFFFFFFFE,   32'd1,          I,     3'b010, 7'd0, 6'd16, 32'd1));
        vecs.push_back(mk(32'h80000000,   32'd4,          I,     3'b101, 7'd0, 6'd17, 32'h08000000));
        n = vecs.size();

        // Reset: done must stay low even with a ready instruction.
        reset = 1'b1;
        bus.cdb_grant = 1'b1;
        drive(vecs[0]);
        tick();
        #1;
        chk("rst.done", {31'd0, bus.issueblk_done}, 32'd0);
        tick();
        chk_cdb("rst", 1'b0, 6'd0, 32'd0);
        bus.issueque_ready = 1'b0;
        reset = 1'b0;
        tick();

        // Single ADD: valid exactly at N+2 for one cycle.
        drive(vecs[0]);
        #1;
        chk("add.done", {31'd0, bus.issueblk_done}, 32'd1);
        tick();
        bus.issueque_ready = 1'b0;
        #1;
        chk("add.n1.valid", {31'd0, bus.cdb_valid}, 32'd0);
        tick();
        chk_cdb("add.n2", 1'b1, 6'd12, 32'd12);
        tick();
        chk("add.n3.valid", {31'd0, bus.cdb_valid}, 32'd0);

        // Back-to-back stream under continuous grant.
        for (int cy = 0; cy < n + 2; cy++) begin
            if (cy < n) drive(vecs[cy]);
            else bus.issueque_ready = 1'b0;
            #1;
            chk($sformatf("str%0d.done", cy), {31'd0, bus.issueblk_done}, (cy < n) ? 32'd1 : 32'd0);
            if (cy >= 2) chk_cdb($sformatf("str%0d", cy), 1'b1, vecs[cy-2].tag, vecs[cy-2].exp);
            else         chk($sformatf("str%0d.valid", cy), {31'd0, bus.cdb_valid}, 32'd0);
            tick();
        end
        chk("str.end.valid", {31'd0, bus.cdb_valid}, 32'd0);

        // Backpressure: third instruction stalls until grant returns.
        a = vecs[0]; b = vecs[1]; c = vecs[4];
        bus.cdb_grant = 1'b0;
        drive(a);
        #1;
        chk("bp.a.done", {31'd0, bus.issueblk_done}, 32'd1);
        tick();
        drive(b);
        #1;
        chk("bp.b.done", {31'd0, bus.issueblk_done}, 32'd1);
        tick();
        drive(c);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp.stall%0d.done", k), {31'd0, bus.issueblk_done}, 32'd0);
            chk_cdb($sformatf("bp.stall%0d", k), 1'b1, a.tag, a.exp);
            tick();
        end
        bus.cdb_grant = 1'b1;
        #1;
        chk("bp.c.done", {31'd0, bus.issueblk_done}, 32'd1);
        tick();
        bus.issueque_ready = 1'b0;
        #1;
        chk_cdb("bp.b", 1'b1, b.tag, b.exp);
        tick();
        chk_cdb("bp.c", 1'b1, c.tag, c.exp);
        tick();
        chk("bp.end.valid", {31'd0, bus.cdb_valid}, 32'd0);

        // Reset with both stages full discards everything.
        bus.cdb_grant = 1'b0;
        drive(vecs[2]);
        tick();
        drive(vecs[3]);
        tick();
        chk("rf.full.valid", {31'd0, bus.cdb_valid}, 32'd1);
        reset = 1'b1;
        drive(vecs[5]);
        #1;
        chk("rf.done", {31'd0, bus.issueblk_done}, 32'd0);
        tick();
        reset = 1'b0;
        bus.issueque_ready = 1'b0;
        bus.cdb_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_cdb($sformatf("rf.after%0d", k), 1'b0, 6'd0, 32'd0);
            tick();
        end

        // Spurious grant while idle leaves state untouched.
        bus.cdb_grant = 1'b1;
        tick();
        tick();
        chk_cdb("spur", 1'b0, 6'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
